// File: rtl/rr_arb_mux.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rr_arb_mux : N-channel round-robin arbiter merging valid/ready streams
//              into one registered output beat.
// Revision   : 1.0
// ---------------------------------------------------------------------------
module rr_arb_mux #(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int SELW  = $clog2(N)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [N-1:0]       in_valid,
  input  logic [N*WIDTH-1:0] in_data,
  output logic [N-1:0]       in_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [SELW-1:0]    out_sel,
  input  logic               out_ready
);

  localparam logic [SELW-1:0] C_LAST = SELW'(N - 1);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic [SELW-1:0]  out_sel_q,   out_sel_d;
  logic [SELW-1:0]  ptr_q,       ptr_d;

  logic             w_load;
  logic             w_found;
  logic [SELW-1:0]  w_grant;
  logic [N-1:0]     w_grant_oh;
  logic [WIDTH-1:0] w_grant_data;
  logic             w_xfer;

  assign w_load = !out_valid_q || out_ready;

  // Scan from ptr upward with wraparound; first requester wins.
  always_comb begin
    w_found    = 1'b0;
    w_grant    = '0;
    w_grant_oh = '0;
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = int'(ptr_q) + k;
      if (idx >= N) idx = idx - N;
      if (!w_found && in_valid[idx]) begin
        w_found         = 1'b1;
        w_grant         = SELW'(idx);
        w_grant_oh[idx] = 1'b1;
      end
    end
  end

  // AND-OR data select keeps in_data off every output except through the register.
  always_comb begin
    w_grant_data = '0;
    for (int i = 0; i < N; i++) begin
      w_grant_data = w_grant_data | (in_data[i*WIDTH +: WIDTH] & {WIDTH{w_grant_oh[i]}});
    end
  end

  assign w_xfer   = reset_n && w_load && w_found;
  assign in_ready = w_xfer ? w_grant_oh : '0;

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    ptr_d       = ptr_q;
    if (w_xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = w_grant_data;
      out_sel_d   = w_grant;
      ptr_d       = (w_grant == C_LAST) ? '0 : w_grant + 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

endmodule
`default_nettype wire
